regfile_sb: RTL and testbench
=============================

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter XLEN, default 32, data width in bits.
REQ-002 Parameter NREGS, default 32, register count; power of two, minimum 2; AW = clog2(NREGS).
REQ-003 Parameter NRD, default 2, number of read ports; range 1..4.
REQ-004 Port clk  in  1  rising-edge clock for all state.
REQ-005 Port rst  in  1  asynchronous, active-high reset.
REQ-006 Port we  in  1  writeback enable.
REQ-007 Port waddr  in  AW  writeback register index.
REQ-008 Port wdata  in  XLEN  writeback data.
REQ-009 Port raddr  in  NRD*AW  read indices; port k occupies bits [k*AW +: AW].
REQ-010 Port rdata  out  NRD*XLEN  read data; port k occupies bits [k*XLEN +: XLEN].
REQ-011 Port iss_valid  in  1  an instruction issues this cycle and will write iss_rd.
REQ-012 Port iss_rd  in  AW  destination index of the issuing instruction.
REQ-013 Port busy  out  NREGS  scoreboard bitmap; bit i = register i has a pending write.
REQ-014 Port rs_busy  out  NRD  per-read-port flag: busy[raddr_k], with bypass adjustment per REQ-024.
REQ-015 Port stall  out  1  OR of all rs_busy bits.

Function
REQ-016 Register 0 SHALL read as 0 on every port, ignore writes, and never set its busy bit.
REQ-017 Reads SHALL be combinational: rdata_k = reg[raddr_k] within the same cycle.
REQ-018 When we=1 and waddr!=0, reg[waddr] SHALL take wdata on the rising clk edge; write latency is 1 cycle.
REQ-019 When iss_valid=1 and iss_rd!=0, busy[iss_rd] SHALL be set on the edge.
REQ-020 When we=1, busy[waddr] SHALL be cleared on the edge.
REQ-021 Issue and writeback to the same nonzero index in one cycle: set wins; busy stays 1 because the new producer is still pending; data is written.
REQ-022 Issue and writeback to different indices in one cycle: both take effect independently.
REQ-023 A writeback to a non-busy register SHALL still write data; busy remains 0.
REQ-024 rs_busy_k SHALL be busy[raddr_k] AND NOT (bypass active for port k per REQ-028); rs_busy_k SHALL be 0 for raddr_k=0.
REQ-025 busy, rs_busy and stall SHALL be combinational from the state and current inputs; no extra registered latency.

Reset
REQ-026 Asserting rst SHALL asynchronously clear all registers to 0 and all busy bits to 0; while rst=1, rdata, busy, rs_busy and stall SHALL be 0.
REQ-027 An issue or write pending in the cycle reset asserts SHALL be discarded; the first edge after deassertion SHALL operate normally.

Configuration
REQ-028 With macro REGFILE_SB_BYPASS_EN defined: when we=1, waddr!=0 and raddr_k==waddr, rdata_k SHALL equal wdata in the same cycle and rs_busy_k SHALL be 0.
REQ-029 Without REGFILE_SB_BYPASS_EN: rdata_k SHALL return the stored value, and rs_busy_k SHALL follow busy[raddr_k] unmodified.

Structure
REQ-030 A shared package regfile_pkg SHALL hold default XLEN/NREGS/NRD constants, the AW derivation function, and the register index typedef.
REQ-031 A single sub-module sb_scoreboard SHALL own the busy bitmap (set/clear/reset logic); the storage array and read muxes stay in regfile_sb.

Verification
REQ-032 Reset then read x0..x31 on both ports -> all rdata=0, busy=0, stall=0.
REQ-033 Write x5=0xDEADBEEF, next cycle raddr0=5 -> rdata0=0xDEADBEEF; write x0=0x1234 -> x0 reads 0.
REQ-034 Issue rd=7, next cycle raddr1=7 -> busy[7]=1, rs_busy[1]=1, stall=1; writeback x7=42 -> busy[7]=0, rdata1=42.
REQ-035 Same cycle: issue rd=3 and writeback x3=9 -> busy[3]=1, reg3=9; issue rd=4 with writeback x3 -> busy[3]=0, busy[4]=1.
REQ-036 Busy x9 pending, we=1 waddr=9 wdata=77 with raddr0=9 -> with BYPASS_EN: rdata0=77, rs_busy[0]=0 in that cycle; without: old value, rs_busy[0]=1.
REQ-037 Set busy x2, x6 with x6 written as 5; assert rst mid-cycle -> immediately busy=0 and all registers 0; first post-reset issue rd=2 sets busy[2]=1.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants, index width helper and register index type for the scoreboarded register file.
package regfile_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int NRD_DEF   = 2;

    function automatic int aw_of(input int nregs);
        return (nregs <= 2) ? 1 : $clog2(nregs);
    endfunction

    localparam int AW_DEF = aw_of(NREGS_DEF);

    typedef logic [AW_DEF-1:0] reg_idx_t;

endpackage

// File: rtl/regfile_sb_scoreboard.sv
// Busy bitmap for the register file: issue sets a bit, writeback clears it, and set wins on a same-index collision.
module sb_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    localparam int AW   = aw_of(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             iss_valid,
    input  logic [AW-1:0]    iss_rd,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    output logic [NREGS-1:0] busy
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    always_comb begin
        busy_d = busy_q;
        if (we) begin
            busy_d[waddr] = 1'b0;
        end
        // Set after clear so a new producer stays pending over the retiring one.
        if (iss_valid && (iss_rd != '0)) begin
            busy_d[iss_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;

endmodule

// File: rtl/regfile_sb.sv
// Register file with combinational read ports and an issue/writeback scoreboard.
// Optional REGFILE_SB_BYPASS_EN forwards same-cycle writeback data to matching read ports.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = NRD_DEF,
    localparam int AW   = aw_of(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic [XLEN-1:0]     wdata,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD*XLEN-1:0] rdata,
    input  logic                iss_valid,
    input  logic [AW-1:0]       iss_rd,
    output logic [NREGS-1:0]    busy,
    output logic [NRD-1:0]      rs_busy,
    output logic                stall
);

    logic [XLEN-1:0] regs_q [NREGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs_q[waddr] <= wdata;
        end
    end

    sb_scoreboard #(
        .NREGS (NREGS)
    ) u_sb (
        .clk       (clk),
        .rst       (rst),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .we        (we),
        .waddr     (waddr),
        .busy      (busy)
    );

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] stored;
        logic            byp;

        assign ra     = raddr[k*AW +: AW];
        assign stored = (ra == '0) ? '0 : regs_q[ra];
`ifdef REGFILE_SB_BYPASS_EN
        assign byp    = we && (waddr != '0) && (ra == waddr);
`else
        assign byp    = 1'b0;
`endif
        // Gated by rst so a bypassed wdata cannot leak out during reset.
        assign rdata[k*XLEN +: XLEN] = rst ? '0 : (byp ? wdata : stored);
        assign rs_busy[k]            = ~rst & busy[ra] & ~byp & (ra != '0);
    end

    assign stall = |rs_busy;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb with default parameters (XLEN=32, NREGS=32, NRD=2).
module tb_regfile_sb;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int AW    = 5;

    logic                clk;
    logic                rst;
    logic                we;
    logic [AW-1:0]       waddr;
    logic [XLEN-1:0]     wdata;
    logic [NRD*AW-1:0]   raddr;
    logic [NRD*XLEN-1:0] rdata;
    logic                iss_valid;
    logic [AW-1:0]       iss_rd;
    logic [NREGS-1:0]    busy;
    logic [NRD-1:0]      rs_busy;
    logic                stall;

    int n_tests;
    int n_fail;

    regfile_sb dut (
        .clk       (clk),
        .rst       (rst),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .raddr     (raddr),
        .rdata     (rdata),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .busy      (busy),
        .rs_busy   (rs_busy),
        .stall     (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input logic [AW-1:0] r0, input logic [AW-1:0] r1);
        raddr = {r1, r0};
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b1;
        we        = 1'b1;
        waddr     = 5'd3;
        wdata     = 32'hFFFF_FFFF;
        iss_valid = 1'b1;
        iss_rd    = 5'd3;
        raddr     = '0;
        #3;
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_stall", 64'(stall), 64'h0);
        chk("rst_rdata", 64'(rdata), 64'h0);
        #17;
        we        = 1'b0;
        iss_valid = 1'b0;
        rst       = 1'b0;
        tick();

        for (int i = 0; i < NREGS; i++) begin
            set_rd(5'(i), 5'(i));
            #1;
            chk("read_zero", 64'(rdata), 64'h0);
        end
        chk("init_busy", 64'(busy), 64'h0);
        chk("init_stall", 64'(stall), 64'h0);

        we = 1'b1; waddr = 5'd5; wdata = 32'hDEAD_BEEF;
        tick();
        we = 1'b0; set_rd(5'd5, 5'd0);
        #1;
        chk("x5_read", 64'(rdata[31:0]), 64'hDEAD_BEEF);
        we = 1'b1; waddr = 5'd0; wdata = 32'h1234;
        tick();
        we = 1'b0; set_rd(5'd0, 5'd0);
        #1;
        chk("x0_ignores_write", 64'(rdata), 64'h0);
        chk("x0_busy", 64'(busy), 64'h0);

        iss_valid = 1'b1; iss_rd = 5'd7;
        tick();
        iss_valid = 1'b0; set_rd(5'd0, 5'd7);
        #1;
        chk("busy7_set", 64'(busy), 64'h80);
        chk("rs_busy_p1", 64'(rs_busy), 64'h2);
        chk("stall_p1", 64'(stall), 64'h1);
        we = 1'b1; waddr = 5'd7; wdata = 32'd42;
        tick();
        we = 1'b0;
        #1;
        chk("busy7_clear", 64'(busy), 64'h0);
        chk("x7_read_p1", 64'(rdata[63:32]), 64'd42);
        chk("stall_clear", 64'(stall), 64'h0);

        iss_valid = 1'b1; iss_rd = 5'd3;
        we = 1'b1; waddr = 5'd3; wdata = 32'd9;
        tick();
        iss_valid = 1'b0; we = 1'b0; set_rd(5'd3, 5'd0);
        #1;
        chk("same_idx_busy", 64'(busy), 64'h8);
        chk("same_idx_data", 64'(rdata[31:0]), 64'd9);
        chk("rs_busy_p0", 64'(rs_busy), 64'h1);
        iss_valid = 1'b1; iss_rd = 5'd4;
        we = 1'b1; waddr = 5'd3; wdata = 32'd10;
        tick();
        iss_valid = 1'b0; we = 1'b0;
        #1;
        chk("diff_idx_busy", 64'(busy), 64'h10);
        chk("diff_idx_data", 64'(rdata[31:0]), 64'd10);

        we = 1'b1; waddr = 5'd8; wdata = 32'h55;
        tick();
        we = 1'b0; set_rd(5'd8, 5'd4);
        #1;
        chk("nonbusy_wr_busy", 64'(busy), 64'h10);
        chk("nonbusy_wr_data", 64'(rdata[31:0]), 64'h55);
        chk("rs_busy_x4", 64'(rs_busy), 64'h2);
        we = 1'b1; waddr = 5'd4; wdata = 32'd1;
        tick();

        waddr = 5'd9; wdata = 32'd11;
        tick();
        we = 1'b0; iss_valid = 1'b1; iss_rd = 5'd9;
        tick();
        iss_valid = 1'b0;
        we = 1'b1; waddr = 5'd9; wdata = 32'd77; set_rd(5'd9, 5'd0);
        #1;
`ifdef REGFILE_SB_BYPASS_EN
        chk("bypass_rdata", 64'(rdata[31:0]), 64'd77);
        chk("bypass_rs_busy", 64'(rs_busy), 64'h0);
`else
        chk("nobypass_rdata", 64'(rdata[31:0]), 64'd11);
        chk("nobypass_rs_busy", 64'(rs_busy), 64'h1);
`endif
        chk("wb_cycle_busy", 64'(busy), 64'h200);
        tick();
        we = 1'b0;
        #1;
        chk("x9_after_wb", 64'(rdata[31:0]), 64'd77);
        chk("busy9_clear", 64'(busy), 64'h0);

        iss_valid = 1'b1; iss_rd = 5'd2;
        tick();
        iss_rd = 5'd6;
        tick();
        we = 1'b1; waddr = 5'd6; wdata = 32'd5;
        tick();
        iss_valid = 1'b0; we = 1'b0; set_rd(5'd6, 5'd2);
        #1;
        chk("pre_rst_busy", 64'(busy), 64'h44);
        chk("pre_rst_x6", 64'(rdata[31:0]), 64'd5);
        iss_valid = 1'b1; iss_rd = 5'd5;
        we = 1'b1; waddr = 5'd6; wdata = 32'd99;
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", 64'(busy), 64'h0);
        chk("mid_rst_rdata", 64'(rdata), 64'h0);
        chk("mid_rst_stall", 64'(stall), 64'h0);
        tick();
        #2;
        iss_valid = 1'b0; we = 1'b0;
        rst = 1'b0;
        #1;
        set_rd(5'd6, 5'd5);
        #1;
        chk("post_rst_x6", 64'(rdata[31:0]), 64'h0);
        chk("post_rst_x5", 64'(rdata[63:32]), 64'h0);
        chk("post_rst_busy", 64'(busy), 64'h0);
        iss_valid = 1'b1; iss_rd = 5'd2;
        tick();
        iss_valid = 1'b0;
        #1;
        chk("post_rst_issue", 64'(busy), 64'h4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
